// File: rtl/rptr_empty_ctrl_if.sv
// rtl/rptr_empty_ctrl_if.sv - read-side pointer/empty-flag bundle for the async FIFO
//
// Groups the signals exchanged between the read-pointer controller and the
// read-domain environment: the consumer's read request, the synchronized Gray
// write pointer coming in, and the address / pointer / status flags going out.
//
// Signals:
//   rinc        consumer read request
//   wptr_sync   Gray write pointer already synchronized into rclk
//   raddr       RAM read address
//   rptr        Gray read pointer, to the read-to-write synchronizer
//   rempty      registered FIFO-empty flag
//   runderflow  sticky flag, read attempted while empty
//   rfill       registered fill level        (RD_FILL_LEVEL_EN only)
//   raempty     registered almost-empty flag (RD_FILL_LEVEL_EN only)
//
// Modports:
//   slave   the controller (rptr_empty_ctrl)
//   master  the read-domain environment driving rinc / wptr_sync
//
// Optional macro: RD_FILL_LEVEL_EN adds rfill and raempty.

interface rptr_empty_ctrl_if #(
  parameter int ADDRSIZE = 9
);
  logic                rinc;
  logic [ADDRSIZE:0]   wptr_sync;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                runderflow;
`ifdef RD_FILL_LEVEL_EN
  logic [ADDRSIZE:0]   rfill;
  logic                raempty;
`endif

  modport slave (
    input  rinc,
    input  wptr_sync,
    output raddr,
    output rptr,
    output rempty,
`ifdef RD_FILL_LEVEL_EN
    output rfill,
    output raempty,
`endif
    output runderflow
  );

  modport master (
    output rinc,
    output wptr_sync,
    input  raddr,
    input  rptr,
    input  rempty,
`ifdef RD_FILL_LEVEL_EN
    input  rfill,
    input  raempty,
`endif
    input  runderflow
  );
endinterface

// File: rtl/rptr_empty_ctrl.sv
// rtl/rptr_empty_ctrl.sv - async FIFO read pointer and empty-flag controller
//
// Lives in the rclk domain, directly downstream of the write-to-read pointer
// synchronizer. Keeps a binary read counter, derives the RAM read address and
// the Gray read pointer returned to the write side, and produces a registered
// empty flag plus a sticky underflow flag.
//
// Ports:
//   rclk   read-domain clock
//   r_rst  synchronous active-high reset, highest priority
//   bus    rptr_empty_ctrl_if.slave: rinc, wptr_sync in;
//          raddr, rptr, rempty, runderflow (rfill, raempty) out
//
// Parameters:
//   ADDRSIZE       RAM address width, depth 2^ADDRSIZE, pointers ADDRSIZE+1 bits
//   AEMPTY_THRESH  almost-empty threshold in words (RD_FILL_LEVEL_EN only)
//
// Optional macro: RD_FILL_LEVEL_EN adds the registered fill level and the
// almost-empty flag.

module rptr_empty_ctrl #(
  parameter int ADDRSIZE = 9
`ifdef RD_FILL_LEVEL_EN
  , parameter int AEMPTY_THRESH = 4
`endif
) (
  input  logic                 rclk,
  input  logic                 r_rst,
  rptr_empty_ctrl_if.slave     bus
);

  logic [ADDRSIZE:0] r_rbin;
  logic [ADDRSIZE:0] r_rptr;
  logic              r_rempty;
  logic              r_runderflow;

  logic              w_accept;
  logic [ADDRSIZE:0] w_rbin_next;
  logic [ADDRSIZE:0] w_rgray_next;

  // A request while the registered flag says empty is refused outright, even
  // if wptr_sync has just moved; the flag catches up on this same edge.
  assign w_accept     = bus.rinc & ~r_rempty;
  assign w_rbin_next  = r_rbin + {{ADDRSIZE{1'b0}}, w_accept};
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

  // Comparing the next Gray pointer (not the current one) lets empty assert on
  // the very edge that consumes the last word, with no stale-cycle window.
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      r_rbin       <= '0;
      r_rptr       <= '0;
      r_rempty     <= 1'b1;
      r_runderflow <= 1'b0;
    end else begin
      r_rbin   <= w_rbin_next;
      r_rptr   <= w_rgray_next;
      r_rempty <= (w_rgray_next == bus.wptr_sync);
      if (bus.rinc && r_rempty) begin
        r_runderflow <= 1'b1;
      end
    end
  end

  assign bus.raddr      = r_rbin[ADDRSIZE-1:0];
  assign bus.rptr       = r_rptr;
  assign bus.rempty     = r_rempty;
  assign bus.runderflow = r_runderflow;

`ifdef RD_FILL_LEVEL_EN
  localparam logic [ADDRSIZE:0] AEMPTY_LVL = (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] w_wbin_s;
  logic [ADDRSIZE:0] w_rfill_next;
  logic [ADDRSIZE:0] r_rfill;
  logic              r_raempty;

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    w_wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      w_wbin_s[i] = ^(bus.wptr_sync >> i);
    end
  end

  // Uses the synchronized (delayed) write pointer, so the level can only
  // under-report occupancy, never over-report it.
  assign w_rfill_next = w_wbin_s - w_rbin_next;

  always_ff @(posedge rclk) begin
    if (r_rst) begin
      r_rfill   <= '0;
      r_raempty <= 1'b1;
    end else begin
      r_rfill   <= w_rfill_next;
      r_raempty <= (w_rfill_next <= AEMPTY_LVL);
    end
  end

  assign bus.rfill   = r_rfill;
  assign bus.raempty = r_raempty;
`endif

endmodule
